// File: rtl/burst_ser_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : burst_ser_pkg
//  Description : Shared encodings for the burst serializer (field selects,
//                FSM state codes).
//  Revision    : 1.0 - initial release
// ============================================================================
package burst_ser_pkg;

  // Field select tags stored alongside every buffered word
  localparam logic [1:0] SEL_FULL = 2'b11;
  localparam logic [1:0] SEL_LO   = 2'b01;
  localparam logic [1:0] SEL_HI   = 2'b10;
  localparam logic [1:0] SEL_BAD  = 2'b00;

  // Serializer FSM state codes
  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_SHIFT = 1'b1;

endpackage
`default_nettype wire

// File: rtl/burst_serializer_sync_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : sync_fifo
//  Description : Single-clock fall-through FIFO. Head entry is visible on
//                dout whenever the FIFO is non-empty; flush empties it.
//  Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo #(
  parameter int WIDTH = 18,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign full      = (r_count == FULL_CNT);
  assign empty     = (r_count == '0);
  assign count     = r_count;
  assign dout      = mem[r_rd_ptr];
  // Overflow / underflow requests are silently refused
  assign w_do_push = push && !full;
  assign w_do_pop  = pop && !empty;

  // Pointer and occupancy bookkeeping; flush returns to the empty state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage array; contents are don't-care while empty, so no reset
  always_ff @(posedge clk) begin
    if (w_do_push && !flush) mem[r_wr_ptr] <= din;
  end

endmodule
`default_nettype wire

// File: rtl/burst_serializer.sv
`default_nettype none
// ============================================================================
//  Module      : burst_serializer
//  Description : Buffers tagged MRAM words and shifts them out as one
//                gap-free serial burst, LSB- or MSB-first per burst.
//  Revision    : 1.0 - initial release
// ============================================================================
module burst_serializer
  import burst_ser_pkg::*;
#(
  parameter int BUS_WIDTH  = 16,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = $clog2(BUS_WIDTH) + 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        en,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [BUS_WIDTH-1:0]        data_in,
  input  logic [1:0]                  word_sel,
  input  logic                        msb_first,
  input  logic                        start,
  input  logic                        abort,
  output logic                        ser_out,
  output logic                        ser_valid,
  output logic                        word_last,
  output logic                        burst_done,
  output logic                        sel_err,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

  localparam int HALF = BUS_WIDTH / 2;

  logic [BUS_WIDTH+1:0] w_fifo_dout;
  logic                 w_full;
  logic                 w_empty;
  logic [1:0]           w_head_sel;
  logic [BUS_WIDTH-1:0] w_head_data;

  logic [0:0]           r_state;
  logic [BUS_WIDTH-1:0] r_sr;
  logic [CNT_W-1:0]     r_cnt;
  logic                 r_msb;
  logic                 r_ser_out;
  logic                 r_burst_done;
  logic                 r_sel_err;

  logic                 w_push_req;
  logic                 w_push;
  logic                 w_last;
  logic                 w_start_pop;
  logic                 w_chain_pop;
  logic                 w_pop;
  logic                 w_load_msb;
  logic [BUS_WIDTH-1:0] w_field;
  logic [CNT_W-1:0]     w_len;
  logic                 w_load_bit;
  logic [BUS_WIDTH-1:0] w_load_rest;
  logic                 w_next_bit;
  logic [BUS_WIDTH-1:0] w_next_rest;

  // No word can be accepted while reset is held
  assign in_ready    = !w_full && !rst;
  assign w_push_req  = in_valid && in_ready;
  assign w_push      = w_push_req && (word_sel != SEL_BAD) && !abort;

  assign w_last      = (r_state == ST_SHIFT) && (r_cnt == CNT_W'(1));
  assign w_start_pop = (r_state == ST_IDLE) && en && start && !w_empty;
  assign w_chain_pop = w_last && en && !w_empty;
  assign w_pop       = (w_start_pop || w_chain_pop) && !abort;

  // First word of a burst uses the live bit order; later words the latched one
  assign w_load_msb  = (r_state == ST_IDLE) ? msb_first : r_msb;

  assign w_head_sel  = w_fifo_dout[BUS_WIDTH+1:BUS_WIDTH];
  assign w_head_data = w_fifo_dout[BUS_WIDTH-1:0];

  sync_fifo #(
    .WIDTH (BUS_WIDTH + 2),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (w_push),
    .pop   (w_pop),
    .flush (abort),
    .din   ({word_sel, data_in}),
    .dout  (w_fifo_dout),
    .full  (w_full),
    .empty (w_empty),
    .count (fifo_count)
  );

  // Extract the selected field, aligned to the end that is emitted first
  always_comb begin
    w_field = w_head_data;
    w_len   = CNT_W'(BUS_WIDTH);
    case (w_head_sel)
      SEL_LO: begin
        w_field = w_load_msb ? {w_head_data[HALF-1:0], {HALF{1'b0}}}
                             : {{HALF{1'b0}}, w_head_data[HALF-1:0]};
        w_len   = CNT_W'(HALF);
      end
      SEL_HI: begin
        w_field = w_load_msb ? {w_head_data[BUS_WIDTH-1:HALF], {HALF{1'b0}}}
                             : {{HALF{1'b0}}, w_head_data[BUS_WIDTH-1:HALF]};
        w_len   = CNT_W'(HALF);
      end
      default: begin
        w_field = w_head_data;
        w_len   = CNT_W'(BUS_WIDTH);
      end
    endcase
  end

  // The first bit goes straight to the output register, the rest stays queued
  assign w_load_bit  = w_load_msb ? w_field[BUS_WIDTH-1] : w_field[0];
  assign w_load_rest = w_load_msb ? (w_field << 1) : (w_field >> 1);
  assign w_next_bit  = r_msb ? r_sr[BUS_WIDTH-1] : r_sr[0];
  assign w_next_rest = r_msb ? (r_sr << 1) : (r_sr >> 1);

  // Serializer FSM: load, shift, chain to next word or finish the burst
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_sr         <= '0;
      r_cnt        <= '0;
      r_msb        <= 1'b0;
      r_ser_out    <= 1'b0;
      r_burst_done <= 1'b0;
      r_sel_err    <= 1'b0;
    end else begin
      r_burst_done <= 1'b0;
      r_sel_err    <= w_push_req && (word_sel == SEL_BAD) && !abort;
      if (abort) begin
        r_state   <= ST_IDLE;
        r_sr      <= '0;
        r_cnt     <= '0;
        r_ser_out <= 1'b0;
      end else if (en) begin
        case (r_state)
          ST_IDLE: begin
            if (w_start_pop) begin
              r_state   <= ST_SHIFT;
              r_msb     <= msb_first;
              r_ser_out <= w_load_bit;
              r_sr      <= w_load_rest;
              r_cnt     <= w_len;
            end
          end
          ST_SHIFT: begin
            if (w_last) begin
              if (!w_empty) begin
                r_ser_out <= w_load_bit;
                r_sr      <= w_load_rest;
                r_cnt     <= w_len;
              end else begin
                r_state      <= ST_IDLE;
                r_ser_out    <= 1'b0;
                r_sr         <= '0;
                r_cnt        <= '0;
                r_burst_done <= 1'b1;
              end
            end else begin
              r_ser_out <= w_next_bit;
              r_sr      <= w_next_rest;
              r_cnt     <= r_cnt - CNT_W'(1);
            end
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign ser_out    = r_ser_out;
  assign ser_valid  = (r_state == ST_SHIFT);
  assign word_last  = w_last;
  assign burst_done = r_burst_done;
  assign sel_err    = r_sel_err;

endmodule
`default_nettype wire
